// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the sequential BCD converter
package calc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] DD_THRESH   = 4'd5;
  localparam logic [3:0] DD_ADD      = 4'd3;

endpackage

// File: rtl/dd_adjust.sv
// rtl/dd_adjust.sv - single-digit add-3 correction applied before each double-dabble shift
module dd_adjust
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // A digit >= 5 would exceed 9 after doubling; adding 3 makes the shift carry into the next digit.
  assign dout = (din >= DD_THRESH) ? din + DD_ADD : din;

endmodule

// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - sequential binary to packed BCD converter, one input bit per clock
module bcd_seq_conv
  import calc_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          RST_N,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SH_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_bin_q, sh_bin_d;
  logic [BCD_W-1:0] sh_bcd_q, sh_bcd_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0] adj_bcd;
  logic [SH_W-1:0]  shift_full;
  logic [SH_W-1:0]  shifted;
  logic             out_bit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dd_adjust u_dd_adjust (
      .din  (sh_bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Bits leaving the top digit mean the value does not fit in DIGITS decimal places.
  assign shift_full = {adj_bcd, sh_bin_q};
  assign shifted    = {shift_full[SH_W-2:0], 1'b0};
  assign out_bit    = shift_full[SH_W-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_bin_d   = sh_bin_q;
    sh_bcd_d   = sh_bcd_q;
    ovf_acc_d  = ovf_acc_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_bin_d  = bin;
          sh_bcd_d  = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_bcd_d  = shifted[SH_W-1:WIDTH];
        sh_bin_d  = shifted[WIDTH-1:0];
        ovf_acc_d = ovf_acc_q | out_bit;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bcd_d      = shifted[SH_W-1:WIDTH];
          overflow_d = ovf_acc_q | out_bit;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_bin_q   <= '0;
      sh_bcd_q   <= '0;
      ovf_acc_q  <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_bin_q   <= sh_bin_d;
      sh_bcd_q   <= sh_bcd_d;
      ovf_acc_q  <= ovf_acc_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule
